// File: rtl/kws_pkg.sv
// Shared types and defaults for the keyword-spotting frame scheduler.
package kws_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_DONE     = 3'd4
    } kws_state_t;

    localparam int unsigned KWS_HOP        = 512;
    localparam int unsigned KWS_SAMPLES    = 16000;
    localparam int unsigned KWS_NUM_FRAMES = 32;
    localparam int unsigned KWS_PEND_DEPTH = 2;

    // Frames needed to cover an utterance; the last one may be partial.
    function automatic int unsigned frames_for(input int unsigned samples,
                                               input int unsigned hop);
        return (samples + hop - 1) / hop;
    endfunction

endpackage

// File: rtl/kws_pend_fifo.sv
// Small queue of completed-but-unissued frames; each entry carries only the
// zero-pad flag of its frame.
module kws_pend_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           push,
    input  logic                           push_pad,
    input  logic                           pop,
    output logic                           head_pad,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_next;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_pad = slots[rd_ptr];

    // A push into a full queue is only taken when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_next = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_next = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_next;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_next;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_pad;
        end
    end

endmodule

// File: rtl/kws_frame_sched.sv
// Utterance scheduler: releases one frame per completed hop into the FFT path,
// counts mel completions, then kicks the DNN and reports utterance completion.
module kws_frame_sched
    import kws_pkg::*;
#(
    parameter int unsigned HOP        = KWS_HOP,
    parameter int unsigned SAMPLES    = KWS_SAMPLES,
    parameter int unsigned NUM_FRAMES = KWS_NUM_FRAMES,
    parameter int unsigned PEND_DEPTH = KWS_PEND_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       mel_done,
    input  logic       dnn_done,
    output logic       fft_start,
    output logic [5:0] frame_idx,
    output logic       pad_last,
    output logic       dnn_start,
    output logic       utt_done,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam int unsigned SW = $clog2(SAMPLES + 1);
    localparam int unsigned HW = $clog2(HOP);
    localparam int unsigned PW = $clog2(PEND_DEPTH + 1);

    if (NUM_FRAMES != frames_for(SAMPLES, HOP)) begin : g_bad_cfg
        $error("kws_frame_sched: NUM_FRAMES must equal ceil(SAMPLES/HOP)");
    end

    kws_state_t    state;
    kws_state_t    state_next;

    logic [SW-1:0] samp_cnt;
    logic [HW-1:0] hop_cnt;
    logic [5:0]    mel_cnt;
    logic [5:0]    issued_cnt;
    logic          inflight;
    logic [PW-1:0] pend_cnt;

    logic          active;
    logic          sample_in;
    logic          hop_wrap;
    logic          last_sample;
    logic          pad_push;
    logic          push;
    logic          mel_accept;
    logic          issue;
    logic          issue_pad;
    logic          drop;
    logic          all_mel;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_head_pad;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pend_clear;

    assign active      = (state == ST_COLLECT) || (state == ST_DRAIN);
    assign sample_in   = (state == ST_COLLECT) && in_valid;
    assign hop_wrap    = sample_in && (hop_cnt == HW'(HOP - 1));
    assign last_sample = sample_in && (samp_cnt == SW'(SAMPLES - 1));
    assign pad_push    = last_sample && !hop_wrap;
    assign push        = hop_wrap || pad_push;
    assign mel_accept  = active && inflight && mel_done;
    assign all_mel     = (mel_cnt == 6'(NUM_FRAMES));

    // A frame completing this cycle can issue straight away, and a mel_done
    // this cycle frees the FFT path for an issue on the same edge.
    assign issue     = active && ((pend_cnt != '0) || push) && (!inflight || mel_accept);
    assign issue_pad = fifo_empty ? pad_push : fifo_head_pad;
    assign drop      = push && fifo_full && !issue;

    assign fifo_push  = push && !drop && !(issue && fifo_empty);
    assign fifo_pop   = issue && !fifo_empty;
    assign pend_clear = (state == ST_DONE);

    kws_pend_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .clear    (pend_clear),
        .push     (fifo_push),
        .push_pad (pad_push),
        .pop      (fifo_pop),
        .head_pad (fifo_head_pad),
        .count    (pend_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (last_sample) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (all_mel) begin
                    state_next = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (dnn_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Dropped frames still consume an index and a mel credit so the frame
    // numbering and the drain count stay aligned with the audio.
    always_ff @(posedge clk) begin
        if (rst || state == ST_DONE) begin
            samp_cnt   <= '0;
            hop_cnt    <= '0;
            mel_cnt    <= '0;
            issued_cnt <= '0;
            inflight   <= 1'b0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                samp_cnt <= SW'(1);
                hop_cnt  <= HW'(1);
            end else if (sample_in) begin
                samp_cnt <= samp_cnt + 1'b1;
                hop_cnt  <= hop_wrap ? '0 : hop_cnt + 1'b1;
            end
            issued_cnt <= issued_cnt + 6'(issue || drop);
            mel_cnt    <= mel_cnt + 6'(mel_accept) + 6'(drop);
            if (issue) begin
                inflight <= 1'b1;
            end else if (mel_accept) begin
                inflight <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fft_start <= 1'b0;
            frame_idx <= '0;
            pad_last  <= 1'b0;
            dnn_start <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fft_start <= issue;
            frame_idx <= issue ? issued_cnt : '0;
            pad_last  <= issue && issue_pad;
            dnn_start <= (state == ST_DRAIN) && all_mel;
            overrun   <= overrun || drop;
        end
    end

    assign utt_done  = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: doc/kws_frame_sched.md
# kws_frame_sched

Utterance-level scheduler for the keyword-spotting pipeline: pre-emphasis, framing, hamming, FFT, mel, DNN. It counts incoming audio samples and releases one frame at a time into the framing/hamming/FFT path once each hop of samples has arrived. It counts mel-frame completions, and after the last frame it starts the DNN and reports utterance completion. It sits in `kws` beside the datapath and drives only control strobes; sample data bypasses it.

## Interface
- `HOP`, 512: samples per frame advance.
- `SAMPLES`, 16000: samples per utterance.
- `NUM_FRAMES`, 32: frames per utterance; must equal ceil(SAMPLES/HOP).
- `PEND_DEPTH`, 2: maximum completed-but-unissued frames.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: one audio sample accepted this cycle (same strobe the pre-emphasis stage sees).
- `mel_done` in 1: mel stage finished one frame (1-cycle pulse).
- `dnn_done` in 1: DNN result valid (1-cycle pulse).
- `fft_start` out 1: 1-cycle pulse; release the next frame into framing/hamming/FFT.
- `frame_idx` out 6: index of the frame being released, valid with `fft_start`.
- `pad_last` out 1: valid with `fft_start`; final partial frame, zero-pad to HOP.
- `dnn_start` out 1: 1-cycle pulse; all mel frames present.
- `utt_done` out 1: 1-cycle pulse; utterance classified.
- `overrun` out 1: sticky; a frame was dropped because the pending queue was full.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, DRAIN, CLASSIFY, DONE.
- IDLE:
  - first `in_valid` counts as sample 1 and moves to COLLECT.
  - `mel_done` and `dnn_done` are ignored.
- COLLECT:
  - `samp_cnt` increments per `in_valid`; `hop_cnt` wraps at HOP.
  - When `hop_cnt` wraps (HOP-th sample of a hop), `pending` increments.
  - When `samp_cnt` reaches SAMPLES: if `hop_cnt` is nonzero, a final pending frame is queued with the pad flag set (default: 128 residual samples). Then go to DRAIN.
  - If SAMPLES is a multiple of HOP, no padded frame is queued.
- Issue rule, in COLLECT and DRAIN:
  - Applies when `pending` > 0 and `inflight` = 0.
  - Assert `fft_start` with `frame_idx` = `issued_cnt` and `pad_last` = the pad flag of the head entry.
  - Then `pending` decrements, `inflight` = 1 and `issued_cnt` increments.
- `mel_done`:
  - clears `inflight` and increments `mel_cnt`.
  - `mel_done` while `inflight` = 0 is ignored and does not count.
- DRAIN: when `mel_cnt` = NUM_FRAMES, pulse `dnn_start` and go to CLASSIFY.
- CLASSIFY: `dnn_done` goes to DONE.
- DONE: pulse `utt_done` for one cycle, clear all counters (not `overrun`), go to IDLE.
- `in_valid` in DRAIN, CLASSIFY or DONE is ignored and not counted.
- Frame drop: if a hop completes while `pending` = PEND_DEPTH and no issue occurs that cycle:
  - the frame is dropped and `overrun` is set;
  - `issued_cnt` advances anyway, so indices stay aligned;
  - `mel_cnt` is credited by 1 so DRAIN still terminates.
- Counter widths:
  - `samp_cnt`: clog2(SAMPLES+1).
  - `hop_cnt`: clog2(HOP).
  - `pending`: clog2(PEND_DEPTH+1).
  - `mel_cnt` and `issued_cnt`: 6 bits.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0, `overrun` 0.
- `fft_start` is registered. It asserts the cycle after the `in_valid` that completes a hop, if `inflight` = 0.
- Otherwise `fft_start` asserts the cycle after the `mel_done` that clears `inflight`.
- `dnn_start` is asserted the cycle after `mel_cnt` reaches NUM_FRAMES.
- `utt_done` is asserted the cycle after `dnn_done`.
- Hop completion and issue in the same cycle: `pending` is unchanged.
- `mel_done` and hop completion in the same cycle: `inflight` clears, `pending` increments, and `fft_start` follows the next cycle.
- `rst` mid-utterance: everything returns to reset values on the next edge. Later `mel_done`/`dnn_done` arriving in IDLE are ignored.
- Gaps in `in_valid` of any length are tolerated. Counting pauses and there is no timeout.

## Structure
- `kws_pkg`:
  - state enum;
  - HOP/SAMPLES/NUM_FRAMES defaults;
  - a function computing ceil(SAMPLES/HOP).
- One sub-module, `kws_pend_fifo`: PEND_DEPTH-entry queue of pad flags, with push, pop, count, full and empty.
- The FSM and counters stay in `kws_frame_sched`.

## Test plan
- Nominal utterance: 16000 samples in 512-burst/512-gap pattern, with `mel_done` 300 cycles after each `fft_start`.
  - 32 `fft_start` pulses, `frame_idx` 0..31.
  - `pad_last` only on idx 31.
  - One `dnn_start` after the 32nd `mel_done`, then `utt_done` the cycle after `dnn_done`.
- Back-pressure: continuous `in_valid` with `mel_done` 1200 cycles after issue.
  - `pending` reaches 2.
  - The third queued hop sets `overrun`.
  - `dnn_start` still fires after the 32nd credited frame.
- Simultaneous events: `mel_done` on the same cycle as the 1024th `in_valid` → `fft_start` idx 1 on the next cycle, `pending` = 0.
- Reset mid-frame: `rst` after sample 700 → all outputs 0.
  - A following `mel_done` has no effect.
  - A new utterance restarts at idx 0.
- Extras ignored:
  - 16100 samples → `samp_cnt` stays at 16000 and exactly 32 frames are issued.
  - `dnn_done` in IDLE → no `utt_done`.
- Parameter case: HOP=400, SAMPLES=16000, NUM_FRAMES=40 → 40 frames and no `pad_last`.
